mem_loader: RTL and testbench

- Host-side writer for the SRAM buffers (input, weight, output) read by the matrix-mult wrapper.
- Accepts a narrow DRIVER_WIDTH valid/ready beat stream.
- Packs BEATS beats into one full-width memory word.
- Writes each word through a single-port, active-low cenb/wenb interface at consecutive addresses.
- Replaces the bench/external-mode direct memory pokes with a synthesizable load path.

---
 rtl/matrix_mult_pkg.sv | 25 ++
 rtl/mem_loader_deser.sv | 50 +++++
 rtl/mem_loader.sv | 131 +++++++++++++
 tb/tb_mem_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the matrix-mult wrapper and its SRAM loader.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } mem_loader_state_e;

    // Number of stream beats that make up one memory word.
    function automatic int unsigned loader_beats(input int unsigned width,
                                                 input int unsigned lanes,
                                                 input int unsigned driver_width);
        return (width * lanes) / driver_width;
    endfunction

    // True when the beat width packs exactly into a memory word.
    function automatic bit loader_cfg_ok(input int unsigned width,
                                         input int unsigned lanes,
                                         input int unsigned driver_width);
        return (driver_width != 0) && (((width * lanes) % driver_width) == 0);
    endfunction

endpackage

// File: rtl/mem_loader_deser.sv
// Beat-to-word assembler: BEATS slots plus a beat counter, beat 0 in the LSBs.
module mem_loader_deser
    import matrix_mult_pkg::*;
#(
    parameter int unsigned DRIVER_WIDTH = 8,
    parameter int unsigned BEATS        = 4
) (
    input  logic                            clk_i,
    input  logic                            rstn_async_i,
    input  logic                            clear,
    input  logic                            push,
    input  logic [DRIVER_WIDTH-1:0]         data,
    output logic                            full_c,
    output logic [DRIVER_WIDTH*BEATS-1:0]   word_c
);

    localparam int unsigned DATA_W = DRIVER_WIDTH * BEATS;
    localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BW-1:0]     beat_cnt;
    logic [DATA_W-1:0] slots;

    // The next push completes the word.
    assign full_c = (beat_cnt == BW'(BEATS - 1));

    // Stored slots with the incoming beat overlaid on its slot.
    always_comb begin
        word_c = slots;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_cnt == BW'(i)) begin
                word_c[i*DRIVER_WIDTH +: DRIVER_WIDTH] = data;
            end
        end
    end

    // Slot storage and beat counter.
    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            beat_cnt <= '0;
            slots    <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            slots    <= '0;
        end else if (push) begin
            slots    <= word_c;
            beat_cnt <= full_c ? '0 : beat_cnt + BW'(1);
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Stream-to-SRAM loader: packs narrow beats into words and writes them at consecutive addresses.
module mem_loader
    import matrix_mult_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned LANES        = 4,
    parameter int unsigned DRIVER_WIDTH = 8,
    parameter int unsigned SIZE         = 256
) (
    input  logic                       clk_i,
    input  logic                       rstn_async_i,
    input  logic                       start_i,
    input  logic [$clog2(SIZE)-1:0]    base_addr_i,
    input  logic [$clog2(SIZE):0]      num_words_i,
    input  logic [DRIVER_WIDTH-1:0]    s_data_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic                       mem_cenb_o,
    output logic                       mem_wenb_o,
    output logic [$clog2(SIZE)-1:0]    mem_addr_o,
    output logic [LANES*WIDTH-1:0]     mem_d_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned DATA_W = LANES * WIDTH;
    localparam int unsigned BEATS  = loader_beats(WIDTH, LANES, DRIVER_WIDTH);
    localparam int unsigned AW     = $clog2(SIZE);
    localparam int unsigned NW     = AW + 1;
    localparam bit          CFG_OK = loader_cfg_ok(WIDTH, LANES, DRIVER_WIDTH);

    if (!CFG_OK) begin : g_cfg_check
        $error("mem_loader: DRIVER_WIDTH must divide LANES*WIDTH");
    end

    mem_loader_state_e state, state_d;
    logic [AW-1:0]     wr_addr, wr_addr_d;
    logic [NW-1:0]     num_words, num_words_d;
    logic [NW-1:0]     word_cnt, word_cnt_d;
    logic [AW-1:0]     addr_d;
    logic [DATA_W-1:0] data_d;
    logic              clear, push, full_c;
    logic [DATA_W-1:0] word_c;

    mem_loader_deser #(
        .DRIVER_WIDTH (DRIVER_WIDTH),
        .BEATS        (BEATS)
    ) u_deser (
        .clk_i        (clk_i),
        .rstn_async_i (rstn_async_i),
        .clear        (clear),
        .push         (push),
        .data         (s_data_i),
        .full_c       (full_c),
        .word_c       (word_c)
    );

    // Next state, config latching, word/address progress and memory port values.
    always_comb begin
        state_d     = state;
        clear       = 1'b0;
        push        = 1'b0;
        wr_addr_d   = wr_addr;
        num_words_d = num_words;
        word_cnt_d  = word_cnt;
        addr_d      = mem_addr_o;
        data_d      = mem_d_o;
        case (state)
            IDLE: begin
                if (start_i) begin
                    clear       = 1'b1;
                    wr_addr_d   = base_addr_i;
                    num_words_d = (num_words_i > NW'(SIZE)) ? NW'(SIZE) : num_words_i;
                    word_cnt_d  = '0;
                    state_d     = (num_words_i == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (s_valid_i && s_ready_o) begin
                    push = 1'b1;
                    if (full_c) begin
                        state_d   = WRITE;
                        addr_d    = wr_addr;
                        data_d    = word_c;
                        wr_addr_d = (wr_addr == AW'(SIZE - 1)) ? '0 : wr_addr + AW'(1);
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt + NW'(1);
                state_d    = (word_cnt_d == num_words) ? DONE : COLLECT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, progress and registered outputs derived from the next state.
    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            state      <= IDLE;
            wr_addr    <= '0;
            num_words  <= '0;
            word_cnt   <= '0;
            s_ready_o  <= 1'b0;
            mem_cenb_o <= 1'b1;
            mem_wenb_o <= 1'b1;
            mem_addr_o <= '0;
            mem_d_o    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_d;
            wr_addr    <= wr_addr_d;
            num_words  <= num_words_d;
            word_cnt   <= word_cnt_d;
            s_ready_o  <= (state_d == COLLECT);
            mem_cenb_o <= (state_d != WRITE);
            mem_wenb_o <= (state_d != WRITE);
            mem_addr_o <= addr_d;
            mem_d_o    <= data_d;
            busy_o     <= (state_d != IDLE);
            done_o     <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed table, hand sequences and random runs vs. a write-list model.
`timescale 1ns/1ps
module tb_mem_loader;

    localparam int unsigned SIZE  = 256;
    localparam int unsigned BEATS = 4;
    localparam int          LIMIT = 4000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        cenb, wenb;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        busy, done;

    always #5 clk = ~clk;

    mem_loader #(
        .WIDTH        (8),
        .LANES        (4),
        .DRIVER_WIDTH (8),
        .SIZE         (SIZE)
    ) dut (
        .clk_i        (clk),
        .rstn_async_i (rstn),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .num_words_i  (num_words),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .mem_cenb_o   (cenb),
        .mem_wenb_o   (wenb),
        .mem_addr_o   (addr),
        .mem_d_o      (wdata),
        .busy_o       (busy),
        .done_o       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observed memory traffic and status counters, sampled mid-cycle.
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int cenb_cnt = 0, done_cnt = 0, busy_cnt = 0, en_bad = 0;

    always @(negedge clk) begin
        if (!cenb) begin
            cenb_cnt <= cenb_cnt + 1;
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
        end
        if (cenb !== wenb) en_bad   <= en_bad + 1;
        if (done)          done_cnt <= done_cnt + 1;
        if (busy)          busy_cnt <= busy_cnt + 1;
    end

    // Stream contents for the current operation and the model's expected writes.
    logic [7:0]  beat_q[$];
    logic [7:0]  exp_a[$];
    logic [31:0] exp_d[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected write list: word w goes to (base+w) mod SIZE, beat k of the word in byte k.
    task automatic model(input logic [7:0] b, input int n_req);
        int n;
        logic [31:0] w_val;
        n = (n_req > int'(SIZE)) ? int'(SIZE) : n_req;
        exp_a.delete();
        exp_d.delete();
        for (int w = 0; w < n; w++) begin
            w_val = '0;
            for (int k = 0; k < int'(BEATS); k++)
                w_val = w_val | (32'(beat_q[w*BEATS + k]) << (8*k));
            exp_a.push_back(8'((int'(b) + w) % int'(SIZE)));
            exp_d.push_back(w_val);
        end
    endtask

    task automatic fill_pattern(input int n);
        beat_q.delete();
        for (int i = 0; i < n; i++) beat_q.push_back(8'(17 * (i + 1)));
    endtask

    task automatic fill_random(input int n);
        beat_q.delete();
        for (int i = 0; i < n; i++) beat_q.push_back(8'($urandom));
    endtask

    // Start one operation and feed beat_q; mode 0 continuous, 1 gapped, 2 random valid.
    task automatic drive_op(input logic [7:0] b, input logic [8:0] n, input int mode,
                            input int busy_at, output int done_at, output int consumed);
        int   cyc;
        logic acc;
        logic v;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_words = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'($urandom); num_words = 9'($urandom);
        consumed = 0; done_at = -1; cyc = 1;
        while (done_at < 0 && cyc < LIMIT) begin
            if (cyc == busy_at) begin
                start = 1'b1; base_addr = 8'h80; num_words = 9'd1;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1) || (consumed % BEATS == 0 && consumed > 0);
                default: v = ($urandom_range(0, 99) < 60);
            endcase
            v = v && (consumed < beat_q.size());
            s_valid = v;
            s_data  = v ? beat_q[consumed] : 8'($urandom);
            @(negedge clk);
            if (done) done_at = cyc;
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) consumed++;
            cyc++;
        end
        start = 1'b0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Run one operation and compare everything observable against the model.
    task automatic run_case(input string tag, input logic [7:0] b, input logic [8:0] n,
                            input int mode, input int busy_at, input int exp_done, output int first);
        int c0, d0, b0, e0, done_at, consumed, nexp, nact;
        first = wr_addr_q.size();
        c0 = cenb_cnt; d0 = done_cnt; b0 = busy_cnt; e0 = en_bad;
        drive_op(b, n, mode, busy_at, done_at, consumed);
        model(b, int'(n));
        nexp = exp_a.size();
        nact = wr_addr_q.size() - first;
        check({tag, "_done_seen"}, 64'(done_at >= 0), 64'(1));
        check({tag, "_nwrites"}, 64'(nact), 64'(nexp));
        check({tag, "_cenb_low"}, 64'(cenb_cnt - c0), 64'(nexp));
        check({tag, "_wenb_eq_cenb"}, 64'(en_bad - e0), 64'(0));
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
        check({tag, "_beats_used"}, 64'(consumed), 64'(nexp * BEATS));
        if (done_at >= 0) check({tag, "_busy_cycles"}, 64'(busy_cnt - b0), 64'(done_at));
        if (exp_done >= 0) check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
        if (nact == nexp) begin
            for (int i = 0; i < nexp; i++) begin
                check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[first+i]), 64'(exp_a[i]));
                check($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[first+i]), 64'(exp_d[i]));
            end
        end
    endtask

    typedef struct {
        string       tag;
        logic [7:0]  base;
        logic [8:0]  num;
        int          mode;
        int          exp_done;
        int          exp_nwr;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  alast;
        logic [31:0] dlast;
    } vec_t;

    vec_t vecs[5];

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
        check({tag, "_cenb"},    64'(cenb),    64'(1));
        check({tag, "_wenb"},    64'(wenb),    64'(1));
        check({tag, "_addr"},    64'(addr),    64'(0));
        check({tag, "_data"},    64'(wdata),   64'(0));
        check({tag, "_busy"},    64'(busy),    64'(0));
        check({tag, "_done"},    64'(done),    64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, c0, done_at, consumed, nw, md;
        vecs[0] = '{"cont",  8'h10, 9'd2,   0, 11,   2,   8'h10, 32'h44332211, 8'h11, 32'h88776655};
        vecs[1] = '{"wrap",  8'hFF, 9'd2,   0, 11,   2,   8'hFF, 32'h44332211, 8'h00, 32'h88776655};
        vecs[2] = '{"zero",  8'h33, 9'd0,   0, 1,    0,   8'h00, 32'h0,        8'h00, 32'h0};
        vecs[3] = '{"gaps",  8'h10, 9'd2,   1, -1,   2,   8'h10, 32'h44332211, 8'h11, 32'h88776655};
        vecs[4] = '{"clamp", 8'h40, 9'd300, 0, 1281, 256, 8'h40, 32'h44332211, 8'h3F, 32'h00EFDECD};

        rstn = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        s_data = '0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int t = 0; t < 5; t++) begin
            fill_pattern(int'(vecs[t].exp_nwr) * BEATS);
            run_case(vecs[t].tag, vecs[t].base, vecs[t].num, vecs[t].mode, -1, vecs[t].exp_done, first);
            if (wr_addr_q.size() - first == vecs[t].exp_nwr && vecs[t].exp_nwr > 0) begin
                check({vecs[t].tag, "_first_addr"}, 64'(wr_addr_q[first]), 64'(vecs[t].a0));
                check({vecs[t].tag, "_first_data"}, 64'(wr_data_q[first]), 64'(vecs[t].d0));
                check({vecs[t].tag, "_last_addr"},  64'(wr_addr_q[$]),     64'(vecs[t].alast));
                check({vecs[t].tag, "_last_data"},  64'(wr_data_q[$]),     64'(vecs[t].dlast));
            end
        end

        // Start while busy: second request during COLLECT must be ignored.
        fill_pattern(8);
        run_case("busystart", 8'h10, 9'd2, 0, 3, 11, first);

        // Reset after two beats of a word: no write, outputs back to reset values at once.
        c0 = cenb_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h30; num_words = 9'd1;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1; s_data = 8'h5A;
        @(posedge clk); #1;
        s_data = 8'h6B;
        @(posedge clk); #1;
        s_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("midrst");
        check("midrst_no_write", 64'(cenb_cnt - c0), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        beat_q.delete();
        beat_q.push_back(8'hA1); beat_q.push_back(8'hA2);
        beat_q.push_back(8'hA3); beat_q.push_back(8'hA4);
        run_case("postrst", 8'h20, 9'd1, 0, -1, 6, first);
        check("postrst_word", 64'(wr_data_q[$]), 64'(32'hA4A3A2A1));
        check("postrst_addr", 64'(wr_addr_q[$]), 64'(8'h20));

        // Randomized operations against the model.
        for (int r = 0; r < 24; r++) begin
            nw = $urandom_range(0, 5);
            md = $urandom_range(0, 2);
            fill_random(nw * BEATS);
            run_case($sformatf("rnd%0d", r), 8'($urandom), 9'(nw), md, -1,
                     (md == 0) ? ((nw == 0) ? 1 : (BEATS + 1) * nw + 1) : -1, first);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
